// File: rtl/fp_decode_if.sv
// fp_decode_if -- handshake bundle between a float-code producer, the
// fp_decode block and the consumer of the linear result.
//
// Signals:
//   in_valid / in_ready   producer -> decoder handshake
//   S, E, F               sign, exponent (left-shift count), unsigned significand
//   out_valid / out_ready decoder -> consumer handshake
//   D                     two's-complement linear result
//   busy                  decoder is not idle
//
// Modports:
//   master  producer/consumer side (drives inputs, observes results)
//   slave   decoder side
interface fp_decode_if #(
   parameter int DW = 12,
   parameter int EW = 3,
   parameter int FW = 4
);
   logic          in_valid;
   logic          in_ready;
   logic          S;
   logic [EW-1:0] E;
   logic [FW-1:0] F;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] D;
   logic          busy;

   modport master (
      output in_valid, S, E, F, out_ready,
      input  in_ready, out_valid, D, busy
   );

   modport slave (
      input  in_valid, S, E, F, out_ready,
      output in_ready, out_valid, D, busy
   );
endinterface

// File: rtl/fp_decode.sv
// fp_decode -- converts a {S, E, F} float code into a DW-bit two's-complement
// value equal to (-1)^S * F * 2^E.
//
// A single left shift is applied per SHIFT cycle instead of a barrel shifter.
// The sign is applied in one extra cycle (SIGN), and the result is held in
// DONE until the consumer takes it. Only one conversion is in flight.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     fp_decode_if.slave: in_valid/in_ready/S/E/F on the input side,
//           out_valid/out_ready/D on the output side, busy = not IDLE
module fp_decode #(
   parameter int DW = 12,   // output width, must be >= FW + 2**EW
   parameter int EW = 3,    // exponent width
   parameter int FW = 4     // significand width
) (
   input  logic         clk,
   input  logic         rst_n,
   fp_decode_if.slave   bus
);

   // Magnitude is one bit narrower than D: the top bit of D is the sign.
   localparam int MW = DW - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      SIGN  = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [MW-1:0] mag_q,   mag_d;
   logic [EW-1:0] cnt_q,   cnt_d;
   logic          sgn_q,   sgn_d;
   logic [DW-1:0] d_q,     d_d;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mag_q   <= '0;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         d_q     <= '0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         d_q     <= d_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and datapath
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a hold default first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d = state_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      sgn_d   = sgn_q;
      d_d     = d_q;

      unique case (state_q)
         IDLE: begin
            // Inputs are captured only here; later changes on S/E/F are ignored.
            if (bus.in_valid) begin
               mag_d   = {{(MW-FW){1'b0}}, bus.F};
               cnt_d   = bus.E;
               sgn_d   = bus.S;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (cnt_q == '0) begin
               state_d = SIGN;
            end else begin
               // No bit can fall off the top: DW >= FW + 2**EW.
               mag_d = {mag_q[MW-2:0], 1'b0};
               cnt_d = cnt_q - EW'(1);
            end
         end

         SIGN: begin
            // Negating zero yields zero, so negative zero needs no special case.
            d_d     = sgn_q ? (~{1'b0, mag_q} + DW'(1)) : {1'b0, mag_q};
            state_d = DONE;
         end

         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs: decoded from state only, so in_ready never depends on
   // in_valid or out_ready.
   // ------------------------------------------------------------------
   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.busy      = (state_q != IDLE);
      bus.D         = d_q;
   end

endmodule

// File: tb/tb_fp_decode.sv
// tb_fp_decode -- self-checking bench for fp_decode. Expected results come
// from an integer model of (-1)^S * F * 2^E; expected latency is E+2 edges.
module tb_fp_decode;

   localparam int DW = 12;
   localparam int EW = 3;
   localparam int FW = 4;

   logic clk;
   logic rst_n;

   int n_vec = 0;
   int n_err = 0;

   fp_decode_if #(.DW(DW), .EW(EW), .FW(FW)) bus ();

   fp_decode #(.DW(DW), .EW(EW), .FW(FW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: plain signed integer arithmetic, truncated to DW bits.
   function automatic logic [DW-1:0] model(input logic s, input int e, input int f);
      int v;
      logic [31:0] w;
      v = f * (1 << e);
      if (s) v = -v;
      w = v;
      return w[DW-1:0];
   endfunction

   // One complete conversion. Called and returning at 1 time unit after a
   // rising edge. hold > 0 keeps out_ready low for that many cycles after
   // out_valid rises; if inject is set, a new request (ps/pe/pf) is presented
   // during the hold and is still pending on return.
   task automatic run_conv(input logic s, input int e, input int f, input int hold,
                           input bit inject, input logic ps, input int pe, input int pf);
      logic [DW-1:0] exp_d;
      int lat;
      exp_d = model(s, e, f);
      bus.S         = s;
      bus.E         = EW'(e);
      bus.F         = FW'(f);
      bus.in_valid  = 1'b1;
      bus.out_ready = (hold == 0);
      check("in_ready_before_accept", bus.in_ready, 1);
      @(posedge clk); #1;
      // Scramble the inputs after acceptance; the decoder must ignore them.
      bus.in_valid = 1'b0;
      bus.S        = 1'($urandom);
      bus.E        = EW'($urandom);
      bus.F        = FW'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0)
            check("busy_while_converting", {bus.busy, bus.in_ready}, 2'b10);
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, e + 2);
      check("result", bus.D, exp_d);
      if (hold > 0) begin
         if (inject) begin
            bus.S        = ps;
            bus.E        = EW'(pe);
            bus.F        = FW'(pf);
            bus.in_valid = 1'b1;
         end
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_D_stable", bus.D, exp_d);
            check("hold_in_ready_low", bus.in_ready, 0);
         end
         bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("idle_out_valid", bus.out_valid, 0);
      check("idle_in_ready", bus.in_ready, 1);
      check("idle_busy", bus.busy, 0);
      check("D_retained", bus.D, exp_d);
   endtask

   initial begin
      logic rs;
      int   re, rf, rh;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.S         = 1'b0;
      bus.E         = '0;
      bus.F         = '0;
      #12;
      check("reset_D", bus.D, 0);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_in_ready", bus.in_ready, 1);
      check("reset_busy", bus.busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases.
      run_conv(1'b0, 0, 4'b0000, 0, 1'b0, 1'b0, 0, 0);   // zero, minimum latency
      run_conv(1'b0, 7, 4'b1111, 0, 1'b0, 1'b0, 0, 0);   // 0x780, maximum latency
      run_conv(1'b1, 3, 4'b1010, 0, 1'b0, 1'b0, 0, 0);   // -80 = 0xFB0
      run_conv(1'b1, 7, 4'b1111, 0, 1'b0, 1'b0, 0, 0);   // -1920 = 0x880
      run_conv(1'b1, 5, 4'b0000, 0, 1'b0, 1'b0, 0, 0);   // negative zero

      // Backpressure with a request arriving during the hold.
      run_conv(1'b0, 2, 4'b0011, 6, 1'b1, 1'b0, 1, 4'b0101);
      run_conv(1'b0, 1, 4'b0101, 0, 1'b0, 1'b0, 0, 0);

      // Asynchronous reset in the middle of SHIFT.
      bus.S        = 1'b0;
      bus.E        = 3'd6;
      bus.F        = 4'b0001;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_reset_busy", bus.busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_D", bus.D, 0);
      check("async_reset_out_valid", bus.out_valid, 0);
      check("async_reset_in_ready", bus.in_ready, 1);
      check("async_reset_busy", bus.busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) check("no_result_after_reset", bus.out_valid, 0);
      end
      run_conv(1'b0, 1, 4'b0001, 0, 1'b0, 1'b0, 0, 0);   // 0x002, latency 3

      // Randomised conversions with random backpressure.
      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom);
         re = int'($urandom_range(0, 7));
         rf = int'($urandom_range(0, 15));
         rh = int'($urandom_range(0, 3));
         run_conv(rs, re, rf, rh, 1'b0, 1'b0, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
